seq5_track_decoder: RTL and testbench
=====================================

// Module: seq5_track_decoder
// PURPOSE
//  Receive-side decoder for the 5-state up/down code stream produced by the T-FF sequence generator.
//  Per sampled code it recovers the binary index and the direction, and it flags illegal codes and skipped transitions.
//  It also runs an acquire/lock state machine and keeps a wrapping signed position count.
//  Sits between the generator's w[2:0] bus and downstream monitoring logic.
// PARAMETERS
//  LOCK_N  4  consecutive legal FWD/REV transitions in ACQ required to enter LOCK (>=1)
//  POS_W   8  width of position accumulator (two's complement, wraps)
//  ERR_W   8  width of error counter (saturating)
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high; clears all state immediately
//  code_valid  in   1      code_in is sampled this cycle
//  code_in     in   3      generator state w[2:0]
//  index       out  3      decoded index 0..4 of last legal code
//  dir         out  1      last observed direction: 0=forward, 1=reverse
//  locked      out  1      state==LOCK
//  err         out  1      one-cycle pulse on any detected error
//  err_kind    out  2      00 none, 01 illegal code, 10 skipped transition; valid with err
//  err_count   out  ERR_W  saturating count of err pulses
//  pos         out  POS_W  position: +1 per FWD, -1 per REV while locked
// BEHAVIOUR
//  Code map (forward order): 000->0, 010->1, 011->2, 100->3, 110->4. Codes 001, 101, 111 are ILLEGAL.
//  Class of a legal new index n vs. stored prev p:
//   FWD if n==(p+1)%5; REV if n==(p+4)%5; HOLD if n==p; SKIP otherwise.
//  All outputs are registered. Latency: the sampling edge plus one; outputs are visible the cycle after code_valid.
//  code_valid=0: no state, index, pos or count change; err=0.
//  Reset values: index=0, dir=0, locked=0, err=0, err_kind=00, err_count=0, pos=0, state=IDLE, prev=0, lock_cnt=0.
//  States IDLE / ACQ / LOCK:
//   IDLE: legal code -> prev=index=n, lock_cnt=0, go to ACQ. Illegal code -> err, kind 01, stay in IDLE.
//   ACQ:  FWD/REV -> dir updated, prev=index=n, lock_cnt++; when lock_cnt reaches LOCK_N, go to LOCK and clear lock_cnt.
//         The entering transition does not change pos.
//         HOLD -> no change. SKIP -> err, kind 10, prev=index=n, lock_cnt=0, stay in ACQ.
//         Illegal code -> err, kind 01, go to IDLE, index held.
//   LOCK: FWD -> pos+1; REV -> pos-1. On both, dir and index update. Reversal is legal at any time.
//         HOLD -> no change. SKIP -> err, kind 10, prev=index=n, go to ACQ, lock_cnt=0.
//         Illegal code -> err, kind 01, go to IDLE, index held.
//  pos wraps modulo 2^POS_W and holds outside LOCK. It is cleared only by reset.
//  err_count increments on every err pulse and sticks at all-ones.
//  err and err_kind return to 0 on the next cycle unless another error occurs.
//  Reset asserted mid-stream forces reset values asynchronously. The first sample after release is handled as IDLE.
// STRUCTURE
//  seq5_pkg holds:
//   state enum {IDLE, ACQ, LOCK};
//   class enum {FWD, REV, HOLD, SKIP, ILLEGAL};
//   code constants C0..C4 and ERR_NONE/ERR_ILLEGAL/ERR_SKIP;
//   function idx_next(p) = (p==4)?0:p+1.
//  One sub-module, seq5_code2idx: combinational code_in -> {legal, idx[2:0]}.
//  Classifier, FSM, lock counter ($clog2(LOCK_N+1) bits), pos and err counters are in the top.
// TESTING
//  1. Defaults; codes 000,010,011,100,110,000, one per cycle ->
//     locked=1 after the 5th code; 6th code gives pos=1, index=0, dir=0, err=0 throughout.
//  2. From test 1, feed 110,100 -> dir=1, index 4 then 3, pos 1->0->255 (wrap), locked stays 1.
//  3. Locked at index 3, feed 101 -> err=1 for exactly one cycle, err_kind=01, err_count+1, locked=0, index=3.
//     Next legal code enters ACQ.
//  4. Locked at index 0, feed 011 -> err, err_kind=10, index=2, locked=0.
//     Then 100,110,000,010 -> relock, pos unchanged during ACQ.
//  5. Repeated 010 plus code_valid=0 gaps carrying illegal values on code_in -> no err, no pos/index/state change.
//  6. ERR_W=2: five illegal codes -> err_count=3 (saturated).
//     Assert reset between clock edges -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/seq5_pkg.sv
// Shared constants and helpers for the 5-state up/down code stream decoder.
// The generator walks 000 -> 010 -> 011 -> 100 -> 110 -> 000 going forward
// and the reverse of that going backward.
package seq5_pkg;

  // FSM state encodings (plain constants so older code can compare against them)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  // Relationship of a newly sampled code to the previously stored index
  typedef enum logic [2:0] {
    CLS_FWD,
    CLS_REV,
    CLS_HOLD,
    CLS_SKIP,
    CLS_ILLEGAL
  } cls_t;

  // Generator codes in forward order
  localparam logic [2:0] C0 = 3'b000;
  localparam logic [2:0] C1 = 3'b010;
  localparam logic [2:0] C2 = 3'b011;
  localparam logic [2:0] C3 = 3'b100;
  localparam logic [2:0] C4 = 3'b110;

  // Values reported on err_kind
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_SKIP    = 2'b10;

  // Next index in forward order, wrapping 4 back to 0
  function automatic logic [2:0] idx_next(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/seq5_code2idx.sv
// Combinational map from a raw generator code to its index 0..4.
// The three codes the generator never produces are reported as not legal.
module seq5_code2idx
  import seq5_pkg::*;
(
  input  logic [2:0] code,
  output logic       legal,
  output logic [2:0] idx
);

  // Look up the code; unknown codes give legal=0 and idx=0
  always_comb begin
    legal = 1'b1;
    idx   = 3'd0;
    case (code)
      C0:      idx = 3'd0;
      C1:      idx = 3'd1;
      C2:      idx = 3'd2;
      C3:      idx = 3'd3;
      C4:      idx = 3'd4;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq5_track_decoder.sv
// Receive-side tracker for the 5-state up/down code stream.
// Decodes each sampled code, classifies it against the previous index,
// runs an IDLE/ACQ/LOCK acquisition FSM, keeps a wrapping position
// count while locked and a saturating error count.
module seq5_track_decoder
  import seq5_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int POS_W  = 8,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [2:0]       code_in,
  output logic [2:0]       index,
  output logic             dir,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_kind,
  output logic [ERR_W-1:0] err_count,
  output logic [POS_W-1:0] pos
);

  localparam int CNT_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(LOCK_N);

  logic [1:0]       state;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_inc;
  logic             code_legal;
  logic [2:0]       code_idx;
  cls_t             cls;
  logic             err_event;
  logic [1:0]       err_kind_next;

  seq5_code2idx u_code2idx (
    .code  (code_in),
    .legal (code_legal),
    .idx   (code_idx)
  );

  assign lock_cnt_inc = lock_cnt + 1'b1;
  assign locked       = (state == ST_LOCK);

  // Classify the new code against the stored index, which doubles as prev
  always_comb begin
    cls = CLS_SKIP;
    if (!code_legal)
      cls = CLS_ILLEGAL;
    else if (code_idx == idx_next(index))
      cls = CLS_FWD;
    else if (index == idx_next(code_idx))
      cls = CLS_REV;
    else if (code_idx == index)
      cls = CLS_HOLD;
  end

  // An error is an illegal code in any state, or a skip once tracking has started
  always_comb begin
    err_event     = 1'b0;
    err_kind_next = ERR_NONE;
    if (code_valid) begin
      if (cls == CLS_ILLEGAL && (state == ST_IDLE || state == ST_ACQ || state == ST_LOCK)) begin
        err_event     = 1'b1;
        err_kind_next = ERR_ILLEGAL;
      end else if (cls == CLS_SKIP && (state == ST_ACQ || state == ST_LOCK)) begin
        err_event     = 1'b1;
        err_kind_next = ERR_SKIP;
      end
    end
  end

  // Error flag is a single-cycle pulse; the counter sticks at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err       <= 1'b0;
      err_kind  <= ERR_NONE;
      err_count <= '0;
    end else begin
      err      <= err_event;
      err_kind <= err_kind_next;
      if (err_event && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

  // Acquisition FSM, index/direction tracking and position accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      index    <= 3'd0;
      dir      <= 1'b0;
      lock_cnt <= '0;
      pos      <= '0;
    end else if (code_valid) begin
      case (state)
        ST_IDLE: begin
          if (cls != CLS_ILLEGAL) begin
            index    <= code_idx;
            lock_cnt <= '0;
            state    <= ST_ACQ;
          end
        end
        ST_ACQ: begin
          case (cls)
            CLS_FWD, CLS_REV: begin
              dir   <= (cls == CLS_REV);
              index <= code_idx;
              if (lock_cnt_inc == LOCK_TARGET) begin
                state    <= ST_LOCK;
                lock_cnt <= '0;
              end else begin
                lock_cnt <= lock_cnt_inc;
              end
            end
            CLS_SKIP: begin
              index    <= code_idx;
              lock_cnt <= '0;
            end
            CLS_ILLEGAL: state <= ST_IDLE;
            default: ;
          endcase
        end
        ST_LOCK: begin
          case (cls)
            CLS_FWD: begin
              dir   <= 1'b0;
              index <= code_idx;
              pos   <= pos + 1'b1;
            end
            CLS_REV: begin
              dir   <= 1'b1;
              index <= code_idx;
              pos   <= pos - 1'b1;
            end
            CLS_SKIP: begin
              index    <= code_idx;
              lock_cnt <= '0;
              state    <= ST_ACQ;
            end
            CLS_ILLEGAL: state <= ST_IDLE;
            default: ;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq5_track_decoder.sv
// Directed bench for seq5_track_decoder: a table of hand-computed vectors
// walks acquisition, lock, reversal, wrap, illegal/skip errors and gaps,
// then hand-written sequences cover error-count saturation and a reset
// asserted between clock edges.
module tb_seq5_track_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [2:0] code_in;
  logic [2:0] index;
  logic       dir;
  logic       locked;
  logic       err;
  logic [1:0] err_kind;
  logic [7:0] err_count;
  logic [7:0] pos;

  logic       valid2;
  logic [2:0] code2;
  logic [2:0] index2;
  logic       dir2;
  logic       locked2;
  logic       err2;
  logic [1:0] kind2;
  logic [1:0] errcnt2;
  logic [7:0] pos2;

  typedef struct {
    logic       v;
    logic [2:0] code;
    logic [2:0] idx;
    logic       dir;
    logic       lk;
    logic       err;
    logic [1:0] kind;
    logic [7:0] pos;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq5_track_decoder #(.LOCK_N(4), .POS_W(8), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_in    (code_in),
    .index      (index),
    .dir        (dir),
    .locked     (locked),
    .err        (err),
    .err_kind   (err_kind),
    .err_count  (err_count),
    .pos        (pos)
  );

  seq5_track_decoder #(.LOCK_N(4), .POS_W(8), .ERR_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .code_valid (valid2),
    .code_in    (code2),
    .index      (index2),
    .dir        (dir2),
    .locked     (locked2),
    .err        (err2),
    .err_kind   (kind2),
    .err_count  (errcnt2),
    .pos        (pos2)
  );

  task automatic addVec(input logic v, input logic [2:0] code, input logic [2:0] idx,
                        input logic d, input logic lk, input logic e, input logic [1:0] kind,
                        input logic [7:0] p, input logic [7:0] cnt);
    vec_t t;
    t.v = v; t.code = code; t.idx = idx; t.dir = d; t.lk = lk;
    t.err = e; t.kind = kind; t.pos = p; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  // Drive one sample on the falling edge, then settle just after the rising edge
  task automatic applyStimulus(input logic v, input logic [2:0] code);
    @(negedge clk);
    code_valid = v;
    code_in    = code;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t e);
    applied++;
    if ({index, dir, locked, err, err_kind, pos, err_count} !==
        {e.idx, e.dir, e.lk, e.err, e.kind, e.pos, e.cnt}) begin
      miscompares++;
      $display("[TB] FAIL %s: got idx=%0d dir=%0d lk=%0d err=%0d kind=%0d pos=%0d cnt=%0d, want idx=%0d dir=%0d lk=%0d err=%0d kind=%0d pos=%0d cnt=%0d",
               name, index, dir, locked, err, err_kind, pos, err_count,
               e.idx, e.dir, e.lk, e.err, e.kind, e.pos, e.cnt);
    end
  endtask

  initial begin
    vec_t zero;
    reset = 1'b1; code_valid = 1'b0; code_in = 3'b000;
    valid2 = 1'b0; code2 = 3'b000;
    zero.v = 0; zero.code = 0; zero.idx = 0; zero.dir = 0; zero.lk = 0;
    zero.err = 0; zero.kind = 0; zero.pos = 0; zero.cnt = 0;

    //      v  code    idx d lk e kind   pos  cnt
    // acquire and lock, first locked step
    addVec(1, 3'b000, 0, 0, 0, 0, 2'b00, 0,   0);
    addVec(1, 3'b010, 1, 0, 0, 0, 2'b00, 0,   0);
    addVec(1, 3'b011, 2, 0, 0, 0, 2'b00, 0,   0);
    addVec(1, 3'b100, 3, 0, 0, 0, 2'b00, 0,   0);
    addVec(1, 3'b110, 4, 0, 1, 0, 2'b00, 0,   0);
    addVec(1, 3'b000, 0, 0, 1, 0, 2'b00, 1,   0);
    // reverse through zero and wrap
    addVec(1, 3'b110, 4, 1, 1, 0, 2'b00, 0,   0);
    addVec(1, 3'b100, 3, 1, 1, 0, 2'b00, 255, 0);
    // illegal code while locked, then re-acquire from index 3
    addVec(1, 3'b101, 3, 1, 0, 1, 2'b01, 255, 1);
    addVec(1, 3'b100, 3, 1, 0, 0, 2'b00, 255, 1);
    addVec(1, 3'b110, 4, 0, 0, 0, 2'b00, 255, 1);
    addVec(1, 3'b000, 0, 0, 0, 0, 2'b00, 255, 1);
    addVec(1, 3'b010, 1, 0, 0, 0, 2'b00, 255, 1);
    addVec(1, 3'b011, 2, 0, 1, 0, 2'b00, 255, 1);
    addVec(1, 3'b100, 3, 0, 1, 0, 2'b00, 0,   1);
    addVec(1, 3'b110, 4, 0, 1, 0, 2'b00, 1,   1);
    addVec(1, 3'b000, 0, 0, 1, 0, 2'b00, 2,   1);
    // skip 0 -> 2 while locked, then relock without moving pos
    addVec(1, 3'b011, 2, 0, 0, 1, 2'b10, 2,   2);
    addVec(1, 3'b100, 3, 0, 0, 0, 2'b00, 2,   2);
    addVec(1, 3'b110, 4, 0, 0, 0, 2'b00, 2,   2);
    addVec(1, 3'b000, 0, 0, 0, 0, 2'b00, 2,   2);
    addVec(1, 3'b010, 1, 0, 1, 0, 2'b00, 2,   2);
    // holds and invalid gaps carrying junk codes
    addVec(0, 3'b101, 1, 0, 1, 0, 2'b00, 2,   2);
    addVec(1, 3'b010, 1, 0, 1, 0, 2'b00, 2,   2);
    addVec(0, 3'b111, 1, 0, 1, 0, 2'b00, 2,   2);
    addVec(0, 3'b001, 1, 0, 1, 0, 2'b00, 2,   2);
    addVec(0, 3'b011, 1, 0, 1, 0, 2'b00, 2,   2);
    addVec(1, 3'b010, 1, 0, 1, 0, 2'b00, 2,   2);
    // reversal straight out of a hold
    addVec(1, 3'b000, 0, 1, 1, 0, 2'b00, 1,   2);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", zero);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].code);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // error counter saturation on the ERR_W=2 instance, held in IDLE by illegal codes
    begin
      logic [2:0] bad [5];
      logic [1:0] want;
      bad[0] = 3'b001; bad[1] = 3'b101; bad[2] = 3'b111; bad[3] = 3'b001; bad[4] = 3'b101;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        valid2 = 1'b1;
        code2  = bad[i];
        @(posedge clk);
        #1;
        want = (i >= 2) ? 2'd3 : 2'(i + 1);
        applied++;
        if ({errcnt2, err2, kind2, locked2, index2} !== {want, 1'b1, 2'b01, 1'b0, 3'd0}) begin
          miscompares++;
          $display("[TB] FAIL sat%0d: got cnt=%0d err=%0d kind=%0d lk=%0d idx=%0d, want cnt=%0d err=1 kind=1 lk=0 idx=0",
                   i, errcnt2, err2, kind2, locked2, index2, want);
        end
      end
      @(negedge clk);
      valid2 = 1'b0;
    end

    // reset raised between edges must clear outputs before the next edge
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", zero);
    @(negedge clk);
    reset = 1'b0;

    // first sample after release is handled as IDLE
    begin
      vec_t e;
      e = zero;
      e.v = 1; e.code = 3'b010; e.idx = 1;
      applyStimulus(1'b1, 3'b010);
      checkOutput("post_reset_idle", e);
      e.code = 3'b011; e.idx = 2;
      applyStimulus(1'b1, 3'b011);
      checkOutput("post_reset_acq", e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
